// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, branch condition codes, flag bit positions
// and the flag unit state type.
package wisc_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;
   localparam logic [3:0] OP_LLB    = 4'b1010;
   localparam logic [3:0] OP_LHB    = 4'b1011;
   localparam logic [3:0] OP_B      = 4'b1100;
   localparam logic [3:0] OP_BR     = 4'b1101;
   localparam logic [3:0] OP_PCS    = 4'b1110;
   localparam logic [3:0] OP_HLT    = 4'b1111;

   localparam logic [2:0] C_NEQ    = 3'b000;
   localparam logic [2:0] C_EQ     = 3'b001;
   localparam logic [2:0] C_GT     = 3'b010;
   localparam logic [2:0] C_LT     = 3'b011;
   localparam logic [2:0] C_GTE    = 3'b100;
   localparam logic [2:0] C_LTE    = 3'b101;
   localparam logic [2:0] C_OVFL   = 3'b110;
   localparam logic [2:0] C_UNCOND = 3'b111;

   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_N = 0;

   typedef enum logic {RUN, HALTED} state_e;

endpackage

// File: rtl/flag_unit_if.sv
// EX/ID-side bus of the flag unit; master is the pipeline, slave is flag_unit.
interface flag_unit_if #(
   parameter int unsigned DW = 16
);
   logic          ex_valid;
   logic [3:0]    ex_opcode;
   logic          ex_stall;
   logic          ex_flush;
   logic [DW-1:0] alu_result;
   logic          alu_ovfl;
   logic          id_valid;
   logic [3:0]    id_opcode;
   logic [2:0]    id_cond;
   logic [2:0]    F;
   logic [2:0]    F_fwd;
   logic          flag_stall;
   logic          halted;

   modport master (
      output ex_valid, ex_opcode, ex_stall, ex_flush, alu_result, alu_ovfl,
      output id_valid, id_opcode, id_cond,
      input  F, F_fwd, flag_stall, halted
   );

   modport slave (
      input  ex_valid, ex_opcode, ex_stall, ex_flush, alu_result, alu_ovfl,
      input  id_valid, id_opcode, id_cond,
      output F, F_fwd, flag_stall, halted
   );
endinterface

// File: rtl/flag_next_logic.sv
// Per-opcode flag-update rules; shared by the register path and the forward path.
module flag_next_logic
   import wisc_pkg::*;
#(
   parameter int unsigned DW = 16
) (
   input  logic [3:0]    opcode,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_ovfl,
   input  logic [2:0]    f_cur,
   output logic [2:0]    f_next,
   output logic          wr_all,
   output logic          wr_z
);

   always_comb begin
      wr_all = 1'b0;
      wr_z   = 1'b0;
      unique case (opcode)
         OP_ADD, OP_SUB:                 wr_all = 1'b1;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: wr_z   = 1'b1;
         default: ;
      endcase

      // Z-only writers keep V and N from the current register value.
      f_next = f_cur;
      if (wr_all || wr_z) f_next[FLAG_Z] = (alu_result == '0);
      if (wr_all) begin
         f_next[FLAG_V] = alu_ovfl;
         f_next[FLAG_N] = alu_result[DW-1];
      end
   end

endmodule

// File: rtl/flag_unit.sv
// EX-stage {Z,V,N} flag register with branch-dependency forwarding or stalling
// and HLT tracking.
module flag_unit
   import wisc_pkg::*;
#(
   parameter bit          FORWARD = 1'b1,
   parameter int unsigned DW      = 16
) (
   input logic       clk,
   input logic       rst_n,
   flag_unit_if.slave bus
);

   state_e     state_q;
   logic [2:0] f_q;
   logic       halted_q;
   logic [2:0] f_next;
   logic       wr_all, wr_z;
   logic       run, commit, ex_writes_flags, id_needs_flags;

   flag_next_logic #(
      .DW(DW)
   ) u_next (
      .opcode    (bus.ex_opcode),
      .alu_result(bus.alu_result),
      .alu_ovfl  (bus.alu_ovfl),
      .f_cur     (f_q),
      .f_next    (f_next),
      .wr_all    (wr_all),
      .wr_z      (wr_z)
   );

   always_comb begin
      run             = (state_q == RUN);
      commit          = bus.ex_valid & ~bus.ex_stall & ~bus.ex_flush & run;
      ex_writes_flags = bus.ex_valid & ~bus.ex_flush & run & (wr_all | wr_z);
      id_needs_flags  = bus.id_valid & ((bus.id_opcode == OP_B) | (bus.id_opcode == OP_BR)) &
                        (bus.id_cond != C_UNCOND);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= RUN;
         f_q      <= 3'b000;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (commit && (wr_all || wr_z)) f_q <= f_next;
               if (commit && (bus.ex_opcode == OP_HLT)) begin
                  state_q  <= HALTED;
                  halted_q <= 1'b1;
               end
            end
            HALTED: ;
            default: state_q <= RUN;
         endcase
      end
   end

   // A stalled EX instruction cannot commit, so its flags are not forwarded.
   always_comb begin
      bus.F          = f_q;
      bus.halted     = halted_q;
      bus.F_fwd      = f_q;
      bus.flag_stall = 1'b0;
      if (FORWARD) begin
         if (ex_writes_flags && !bus.ex_stall) bus.F_fwd = f_next;
      end else begin
         bus.flag_stall = id_needs_flags & ex_writes_flags;
      end
   end

endmodule

// File: tb/tb_flag_unit.sv
// Drives a forwarding and a stalling flag_unit with identical stimulus and checks
// both against a behavioural flag model.
module tb_flag_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_stall, ex_flush, alu_ovfl, id_valid;
   logic [3:0]  ex_opcode, id_opcode;
   logic [2:0]  id_cond;
   logic [15:0] alu_result;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [2:0]  f_m;
   logic        h_m;

   always #5 clk = ~clk;

   flag_unit_if #(.DW(16)) bus_fw ();
   flag_unit_if #(.DW(16)) bus_nf ();

   assign bus_fw.ex_valid   = ex_valid;
   assign bus_fw.ex_opcode  = ex_opcode;
   assign bus_fw.ex_stall   = ex_stall;
   assign bus_fw.ex_flush   = ex_flush;
   assign bus_fw.alu_result = alu_result;
   assign bus_fw.alu_ovfl   = alu_ovfl;
   assign bus_fw.id_valid   = id_valid;
   assign bus_fw.id_opcode  = id_opcode;
   assign bus_fw.id_cond    = id_cond;
   assign bus_nf.ex_valid   = ex_valid;
   assign bus_nf.ex_opcode  = ex_opcode;
   assign bus_nf.ex_stall   = ex_stall;
   assign bus_nf.ex_flush   = ex_flush;
   assign bus_nf.alu_result = alu_result;
   assign bus_nf.alu_ovfl   = alu_ovfl;
   assign bus_nf.id_valid   = id_valid;
   assign bus_nf.id_opcode  = id_opcode;
   assign bus_nf.id_cond    = id_cond;

   flag_unit #(.FORWARD(1'b1), .DW(16)) dut_fw (.clk(clk), .rst_n(rst_n), .bus(bus_fw));
   flag_unit #(.FORWARD(1'b0), .DW(16)) dut_nf (.clk(clk), .rst_n(rst_n), .bus(bus_nf));

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // 2 = writes Z,V,N; 1 = writes Z only; 0 = writes nothing
   function automatic int flag_class(input logic [3:0] op);
      if (op == 4'd0 || op == 4'd1) return 2;
      if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return 1;
      return 0;
   endfunction

   function automatic logic [2:0] model_next();
      int c = flag_class(ex_opcode);
      logic z = (alu_result == 16'd0);
      if (c == 2) return {z, alu_ovfl, alu_result[15]};
      if (c == 1) return {z, f_m[1:0]};
      return f_m;
   endfunction

   task automatic apply(input bit rst, input bit ev, input logic [3:0] op, input bit st,
                        input bit fl, input logic [15:0] res, input bit ov, input bit iv,
                        input logic [3:0] iop, input logic [2:0] ic);
      bit ex_w, need;
      rst_n = ~rst; ex_valid = ev; ex_opcode = op; ex_stall = st; ex_flush = fl;
      alu_result = res; alu_ovfl = ov; id_valid = iv; id_opcode = iop; id_cond = ic;
      #2;
      ex_w = ev && !fl && !h_m && flag_class(op) != 0;
      need = iv && (iop == 4'd12 || iop == 4'd13) && ic != 3'd7;
      check("F_fw", bus_fw.F, f_m);
      check("F_nf", bus_nf.F, f_m);
      check("fwd_fw", bus_fw.F_fwd, (ex_w && !st) ? model_next() : f_m);
      check("fwd_nf", bus_nf.F_fwd, f_m);
      check("stall_fw", bus_fw.flag_stall, 0);
      check("stall_nf", bus_nf.flag_stall, need && ex_w);
      check("halt_fw", bus_fw.halted, h_m);
      check("halt_nf", bus_nf.halted, h_m);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         f_m = 3'b000;
         h_m = 1'b0;
      end else if (!h_m && ex_valid && !ex_stall && !ex_flush) begin
         f_m = model_next();
         if (ex_opcode == 4'hF) h_m = 1'b1;
      end
      #1;
   endtask

   task automatic idle(input bit rst);
      apply(rst, 0, 4'h0, 0, 0, 16'h0, 0, 0, 4'h0, 3'h0);
   endtask

   initial begin
      f_m = 3'b000;
      h_m = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      ex_valid = 0; ex_opcode = 0; ex_stall = 0; ex_flush = 0;
      alu_result = 0; alu_ovfl = 0; id_valid = 0; id_opcode = 0; id_cond = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      f_m = 3'b000;
      h_m = 1'b0;
      check("rst_F", bus_fw.F, 3'b000);
      check("rst_halt", bus_nf.halted, 1'b0);

      // ADD zero: forwarded in the same cycle, registered next cycle
      apply(0, 1, 4'h0, 0, 0, 16'h0000, 0, 0, 4'h0, 3'h0);
      check("add_fwd", bus_fw.F_fwd, 3'b100);
      tick();
      check("add_F", bus_fw.F, 3'b100);
      apply(0, 1, 4'h1, 0, 0, 16'h8000, 1, 0, 4'h0, 3'h0); tick();
      check("sub_F", bus_nf.F, 3'b011);
      apply(0, 1, 4'h2, 0, 0, 16'h0000, 0, 0, 4'h0, 3'h0); tick();
      check("xor_F", bus_nf.F, 3'b111);
      apply(0, 1, 4'h3, 0, 0, 16'h0000, 0, 0, 4'h0, 3'h0); tick();
      check("red_F", bus_nf.F, 3'b111);

      // Dependent conditional branch stalls exactly one cycle without forwarding
      apply(0, 1, 4'h0, 0, 0, 16'h0001, 0, 1, 4'hC, 3'h1);
      check("dep_stall", bus_nf.flag_stall, 1'b1);
      tick();
      apply(0, 0, 4'h0, 0, 0, 16'h0000, 0, 1, 4'hC, 3'h1);
      check("dep_release", bus_nf.flag_stall, 1'b0);
      check("dep_F", bus_nf.F, 3'b000);
      tick();
      apply(0, 1, 4'h0, 0, 0, 16'h0000, 0, 1, 4'hC, 3'h7);
      check("uncond_nostall", bus_nf.flag_stall, 1'b0);
      tick();

      // No commit under flush, stall, or both
      idle(1); tick();
      apply(0, 1, 4'h0, 0, 1, 16'h0000, 0, 0, 4'h0, 3'h0); tick();
      check("flush_F", bus_fw.F, 3'b000);
      apply(0, 1, 4'h0, 1, 0, 16'h0000, 0, 0, 4'h0, 3'h0); tick();
      check("stall_F", bus_fw.F, 3'b000);
      apply(0, 1, 4'h0, 1, 1, 16'h0000, 0, 0, 4'h0, 3'h0); tick();
      check("both_F", bus_fw.F, 3'b000);

      // HLT freezes flags until reset
      apply(0, 1, 4'h1, 0, 0, 16'h8000, 1, 0, 4'h0, 3'h0); tick();
      apply(0, 1, 4'hF, 0, 0, 16'h0000, 0, 0, 4'h0, 3'h0); tick();
      check("hlt_halted", bus_fw.halted, 1'b1);
      apply(0, 1, 4'h0, 0, 0, 16'h0000, 0, 1, 4'hD, 3'h0);
      check("hlt_nostall", bus_nf.flag_stall, 1'b0);
      check("hlt_fwd", bus_fw.F_fwd, 3'b011);
      tick();
      check("hlt_frozen", bus_fw.F, 3'b011);
      idle(1); tick();
      check("unhalt", bus_fw.halted, 1'b0);
      check("unhalt_F", bus_fw.F, 3'b000);

      // Reset wins over a committing SUB
      apply(1, 1, 4'h1, 0, 0, 16'h8000, 1, 0, 4'h0, 3'h0); tick();
      check("rst_over_sub", bus_nf.F, 3'b000);

      for (int i = 0; i < 2000; i++) begin
         logic [3:0]  op;
         logic [15:0] res;
         logic [3:0]  iop;
         op  = ($urandom_range(0, 59) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         res = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         iop = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(12, 13)) : 4'($urandom);
         apply($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0, op,
               $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, res,
               1'($urandom), 1'($urandom), iop, 3'($urandom));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Producer side of the {Z,V,N} flag bus that branch PC control consumes.
- Sits at the EX stage of the 16-bit WISC pipeline. Captures ALU results and applies per-opcode flag-update rules in a 3-bit flag register.
- Resolves the EX→ID flag dependency for conditional branches, either by forwarding or by stalling.
- Tracks HLT so flags freeze once the core halts.

Parameters:
- FORWARD, 1, 1 = present next-cycle flags combinationally on F_fwd with no stall; 0 = stall the dependent branch one cycle.
- DW, 16, ALU datapath width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_opcode  in  4  EX instruction opcode.
- ex_stall  in  1  EX stage held this cycle; no commit.
- ex_flush  in  1  EX instruction squashed; no commit.
- alu_result  in  DW  ALU output for the EX instruction.
- alu_ovfl  in  1  signed overflow from ADD/SUB.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  4  ID instruction opcode.
- id_cond  in  3  ID branch condition field C.
- F  out  3  registered flags {Z,V,N}, bit 2 = Z, bit 1 = V, bit 0 = N.
- F_fwd  out  3  flags the ID-stage branch must use; equals F when FORWARD=0.
- flag_stall  out  1  request one-cycle ID stall (FORWARD=0 only).
- halted  out  1  HLT has committed.

Behaviour:
- Reset: when rst_n is low at a rising edge, F=3'b000, halted=0, state=RUN. Reset overrides every other input.
- commit = ex_valid & ~ex_stall & ~ex_flush & (state==RUN). When stall and flush are both high, there is no commit.
- Flag classes:
  - ADD 0000 and SUB 0001 write Z, V and N.
  - XOR 0010, SLL 0100, SRA 0101 and ROR 0110 write Z only; V and N hold.
  - All other opcodes write nothing. This includes RED 0011, PADDSB 0111, LW, SW, LLB, LHB, B, BR and PCS.
- Next values:
  - Z = (alu_result == 0).
  - N = alu_result[DW-1].
  - V = alu_ovfl.
- Update: on a rising edge with commit and a flag-writing opcode, F takes its next value; otherwise F holds. The update takes 1 cycle: a value is computed in cycle t and is visible on F in cycle t+1.
- id_needs_flags = id_valid & (id_opcode==1100 | id_opcode==1101) & (id_cond != 3'b111).
- ex_writes_flags = ex_valid & ~ex_flush & (state==RUN) & (opcode is a flag-writing class).
- FORWARD=1:
  - F_fwd = next-flag value when ex_writes_flags & ~ex_stall; otherwise F_fwd = F.
  - flag_stall is constant 0.
- FORWARD=0:
  - F_fwd = F.
  - flag_stall = id_needs_flags & ex_writes_flags, combinational.
  - The pipeline must then advance EX while holding ID. On the next cycle EX no longer writes flags, so flag_stall deasserts and the stall lasts exactly one cycle.
- State machine:
  - RUN → HALTED when commit & ex_opcode==1111.
  - HALTED has no exit except reset.
  - In HALTED: halted=1, F frozen, flag_stall=0, F_fwd=F.
- HLT and flag update in the same cycle cannot occur, since HLT is not a flag writer.
- Unconditional branch (C=111) never stalls and never needs F_fwd.

Decomposition:
- Shared package wisc_pkg:
  - opcode localparams (OP_ADD … OP_HLT);
  - condition-code localparams (C_NEQ … C_UNCOND);
  - flag bit indices FLAG_Z=2, FLAG_V=1, FLAG_N=0;
  - state typedef {RUN, HALTED}.
- One combinational sub-module, flag_next_logic. It takes the opcode, alu_result and alu_ovfl plus the current F, and returns the next flags, a write-all flag and a write-Z-only flag. It is shared by the register-update path and the F_fwd path.

Test Plan:
- Reset, then ADD with alu_result=16'h0000 and alu_ovfl=0 committed → next cycle F=3'b100; with FORWARD=1, F_fwd=3'b100 in the same cycle.
- SUB with result=16'h8000 and ovfl=1 gives F=3'b011. Then XOR with result=16'h0000 gives F=3'b111, because V and N hold. Then RED with result 0 leaves F=3'b111.
- FORWARD=0: EX=ADD while ID=B with C=001 → flag_stall=1 for exactly one cycle, then 0, with F updated. Repeat with C=111 → flag_stall stays 0.
- ADD with ex_flush=1, and separately with ex_stall=1, result 0 → F unchanged (3'b000). Assert both together → F unchanged.
- Commit HLT, then ADD with result 0 → halted=1 from the next cycle and F frozen at its prior value. Pulse rst_n low for one edge → halted=0, F=3'b000.
- rst_n low in the same cycle as a committing SUB → F=3'b000 after the edge, not the SUB flags.
